// File: rtl/pe_buf_arbiter.sv
// pe_buf_arbiter
//   Round-robin arbiter giving NREQ PE controllers burst access to a shared
//   feature-map buffer. A grant is held until the owner marks its final beat,
//   drops its request, or reaches MAX_HOLD beats. After every release there is
//   one idle cycle before the next grant. The round-robin pointer moves to the
//   index just after the releasing owner.
//
// Ports
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   en        in   arbitration enable; only blocks new grants
//   req       in   [NREQ]     per-requester request, level-held for the burst
//   last      in   [NREQ]     per-requester final-beat marker
//   addr_in   in   [NREQ*AW]  requester i address at [i*AW +: AW]
//   gnt       out  [NREQ]     registered one-hot grant
//   mem_en    out             buffer read strobe, one per beat
//   mem_addr  out  [AW]       buffer address, zero when mem_en is low
//   rvalid    out  [NREQ]     read-data-valid to the owner, one cycle after its beat
//   busy      out             high while a grant is held
module pe_buf_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = 13,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   last,
  input  logic [NREQ*AW-1:0] addr_in,
  output logic [NREQ-1:0]   gnt,
  output logic              mem_en,
  output logic [AW-1:0]     mem_addr,
  output logic [NREQ-1:0]   rvalid,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_rvalid, w_rvalid_nxt;
  logic [PW-1:0]   r_owner, w_owner_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;

  logic [PW-1:0]   w_winner;
  logic [PW-1:0]   w_scan;
  logic            w_found;
  logic            w_beat;
  logic            w_final;

  // Cyclic successor of an index; keeps non-power-of-two NREQ in range.
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] v);
    if (v == PW'(NREQ - 1)) begin
      return '0;
    end
    return v + PW'(1);
  endfunction

  // Round-robin scan: first requester at or after r_ptr, wrapping.
  always_comb begin
    w_winner = r_ptr;
    w_found  = 1'b0;
    w_scan   = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req[w_scan]) begin
        w_winner = w_scan;
        w_found  = 1'b1;
      end
      w_scan = next_idx(w_scan);
    end
  end

  // A beat is any BUSY cycle in which the owner still requests.
  assign w_beat   = (r_state == S_BUSY) && req[r_owner];
  assign w_final  = last[r_owner] || (r_cnt == HOLD_LAST);
  assign mem_en   = w_beat;
  assign mem_addr = w_beat ? addr_in[int'(r_owner)*AW +: AW] : '0;

  assign gnt    = r_gnt;
  assign rvalid = r_rvalid;
  assign busy   = (r_state == S_BUSY);

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_owner_nxt  = r_owner;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    // Follows the beat even on the releasing edge.
    w_rvalid_nxt = w_beat ? r_gnt : '0;

    case (r_state)
      S_IDLE: begin
        if (en && w_found) begin
          w_state_nxt = S_BUSY;
          w_gnt_nxt   = NREQ'(1) << w_winner;
          w_owner_nxt = w_winner;
          w_cnt_nxt   = '0;
        end
      end
      S_BUSY: begin
        // Owner dropping req is a release without a beat.
        if (!w_beat || w_final) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = next_idx(r_owner);
        end else begin
          // Release at HOLD_LAST keeps the counter from ever wrapping.
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_owner  <= w_owner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pe_buf_arbiter.sv
// tb_pe_buf_arbiter
//   Bench for pe_buf_arbiter: directed bursts followed by randomized traffic,
//   every cycle compared against a behavioural model of the arbitration rules.
module tb_pe_buf_arbiter;

  localparam int NREQ     = 4;
  localparam int AW       = 13;
  localparam int MAX_HOLD = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              en = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   last = '0;
  logic [NREQ*AW-1:0] addr_in = '0;
  logic [NREQ-1:0]   gnt;
  logic              mem_en;
  logic [AW-1:0]     mem_addr;
  logic [NREQ-1:0]   rvalid;
  logic              busy;

  pe_buf_arbiter #(.NREQ(NREQ), .AW(AW), .MAX_HOLD(MAX_HOLD)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .req      (req),
    .last     (last),
    .addr_in  (addr_in),
    .gnt      (gnt),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .rvalid   (rvalid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: owner index (-1 = nobody), pointer, beats this grant.
  int              m_owner = -1;
  int              m_ptr   = 0;
  int              m_beats = 0;
  logic [NREQ-1:0] m_rvalid = '0;

  // Observations of the DUT itself.
  int              gnt_order[$];
  logic [NREQ-1:0] prev_gnt = '0;
  int              rv_count = 0;
  int              men_count = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic set_addr(input int i, input int val);
    addr_in[i*AW +: AW] = AW'(val);
  endtask

  // Called at posedge+1 with inputs already driven. Checks mid-cycle, advances
  // the model with this cycle's inputs, then moves to the next posedge+1.
  task automatic step();
    logic [NREQ-1:0] exp_gnt;
    logic            exp_men;
    logic [AW-1:0]   exp_addr;
    bit              granted;
    #3;
    exp_gnt = '0;
    exp_men = 1'b0;
    exp_addr = '0;
    if (m_owner >= 0) begin
      exp_gnt[m_owner] = 1'b1;
      exp_men = req[m_owner];
      if (exp_men) exp_addr = addr_in[m_owner*AW +: AW];
    end
    chk("gnt", gnt, exp_gnt);
    chk("busy", busy, m_owner >= 0);
    chk("mem_en", mem_en, exp_men);
    chk("mem_addr", mem_addr, exp_addr);
    chk("rvalid", rvalid, m_rvalid);

    if (gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_order.push_back(i);
    end
    prev_gnt  = gnt;
    rv_count += $countones(rvalid);
    men_count += mem_en ? 1 : 0;

    m_rvalid = exp_men ? exp_gnt : '0;
    if (m_owner < 0) begin
      if (en && req != '0) begin
        granted = 0;
        for (int k = 0; k < NREQ; k++) begin
          if (!granted && req[(m_ptr + k) % NREQ]) begin
            m_owner = (m_ptr + k) % NREQ;
            granted = 1;
          end
        end
        m_beats = 0;
      end
    end else if (req[m_owner]) begin
      m_beats++;
      if (last[m_owner] || m_beats == MAX_HOLD) begin
        m_ptr = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end else begin
      m_ptr = (m_owner + 1) % NREQ;
      m_owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts reset off the clock edge, checks the immediate effect, releases
  // one cycle later at posedge+1.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    m_owner  = -1;
    m_ptr    = 0;
    m_beats  = 0;
    m_rvalid = '0;
    prev_gnt = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    req  = '0;
    last = '0;
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Single requester, incrementing addresses, last on the 4th beat.
    en = 1'b1;
    rv_count = 0;
    gnt_order.delete();
    for (int c = 0; c < 7; c++) begin
      req  = (c <= 4) ? 4'b0001 : 4'b0000;
      last = (c == 4) ? 4'b0001 : 4'b0000;
      set_addr(0, 'h100 + c - 1);
      step();
    end
    chk("r031_rvalid_cnt", rv_count, 4);
    chk("r031_grants", gnt_order.size(), 1);
    // Pointer now at 1: an all-request arbitration must pick requester 1.
    req = 4'b1111;
    step();
    chk("r031_ptr", gnt, 4'b0010);
    idle_cycles(3);

    // Enable gating, and en dropping mid-burst.
    en = 1'b0;
    req = 4'b0010;
    last = '0;
    step();
    step();
    chk("r035_no_grant", gnt, 0);
    en = 1'b1;
    step();
    chk("r035_grant", gnt, 4'b0010);
    en = 1'b0;
    rv_count = 0;
    for (int c = 0; c < 4; c++) begin
      last = (m_owner == 1 && m_beats == 2) ? 4'b0010 : 4'b0000;
      req  = (c < 3) ? 4'b0010 : 4'b0000;
      set_addr(1, $urandom);
      step();
    end
    chk("r035_beats", rv_count, 3);
    en = 1'b1;
    idle_cycles(2);

    // Hold cap: requester 2 never asserts last.
    req = 4'b0100;
    last = '0;
    step();
    men_count = 0;
    for (int c = 0; c < MAX_HOLD; c++) begin
      set_addr(2, $urandom);
      step();
    end
    chk("r033_beats", men_count, MAX_HOLD);
    chk("r033_release", gnt, 0);
    step();
    chk("r033_regrant", gnt, 4'b0100);
    idle_cycles(3);

    // All four request, last on each owner's 2nd beat: order 0,1,2,3,0.
    do_reset();
    gnt_order.delete();
    men_count = 0;
    req = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      last = (m_owner >= 0 && m_beats == 1) ? 4'b1111 : 4'b0000;
      for (int i = 0; i < NREQ; i++) set_addr(i, $urandom);
      step();
    end
    chk("r032_ngrants", gnt_order.size(), 5);
    chk("r032_order0", gnt_order.size() > 0 ? gnt_order[0] : -1, 0);
    chk("r032_order1", gnt_order.size() > 1 ? gnt_order[1] : -1, 1);
    chk("r032_order2", gnt_order.size() > 2 ? gnt_order[2] : -1, 2);
    chk("r032_order3", gnt_order.size() > 3 ? gnt_order[3] : -1, 3);
    chk("r032_order4", gnt_order.size() > 4 ? gnt_order[4] : -1, 0);
    chk("r032_beats", men_count, 10);
    idle_cycles(3);

    // Owner drops req after 3 beats.
    rv_count = 0;
    last = '0;
    for (int c = 0; c < 6; c++) begin
      req = (c == 4) ? 4'b0000 : 4'b0001;
      set_addr(0, $urandom);
      step();
    end
    chk("r034_rvalid_cnt", rv_count, 3);
    idle_cycles(3);

    // Reset during beat 2, then requester 3 alone.
    req = 4'b0001;
    step();
    step();
    chk("r036_pre_rst_gnt", gnt, 4'b0001);
    do_reset();
    req = 4'b1000;
    step();
    chk("r036_post_grant", gnt, 4'b1000);
    idle_cycles(3);

    // Randomized traffic with persistent requests.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
        last[i] = ($urandom_range(0, 3) == 0);
        set_addr(i, $urandom);
      end
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pe_buf_arbiter.md
PE_BUF_ARBITER -- requirements
Module: pe_buf_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of PE controllers sharing the feature-map buffer.
REQ-002 Parameter AW, default 13, buffer word-address width (8192 words).
REQ-003 Parameter MAX_HOLD, default 16, maximum beats per grant before forced release (fairness cap, >=1).
REQ-004 clk  input  1  rising-edge clock; single clock domain.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  arbitration enable; low blocks new grants only.
REQ-007 req  input  NREQ  per-requester access request, level-held for the burst.
REQ-008 last  input  NREQ  per-requester final-beat marker, qualified by req of the same index.
REQ-009 addr_in  input  NREQ*AW  requester i address at bits [i*AW +: AW].
REQ-010 gnt  output  NREQ  registered one-hot grant; all-zero when no owner.
REQ-011 mem_en  output  1  buffer read strobe, one per beat.
REQ-012 mem_addr  output  AW  buffer address, valid when mem_en=1.
REQ-013 rvalid  output  NREQ  read-data-valid to the owner, one cycle after its beat.
REQ-014 busy  output  1  high while a grant is held.

Function
REQ-015 States: IDLE and BUSY; busy SHALL be 1 exactly in BUSY.
REQ-016 IDLE: if en=1 and req!=0, winner = first index with req set, scanning cyclically from round-robin pointer ptr; next edge gnt<=onehot(winner), beat counter<=0, state<=BUSY.
REQ-017 IDLE with en=0 or req=0: gnt stays 0, no state change; last ignored.
REQ-018 Grant latency: req rising in IDLE -> gnt at the next edge; first beat possible in that same cycle.
REQ-019 Beat: in BUSY, beat occurs in any cycle where req[owner]=1; mem_en=1 and mem_addr=addr_in[owner] combinationally in that cycle.
REQ-020 mem_en SHALL be 0 in IDLE and in BUSY cycles with req[owner]=0; mem_addr then = 0.
REQ-021 Beat counter increments on each beat, width clog2(MAX_HOLD)+1, never wraps.
REQ-022 Release on a beat with last[owner]=1 or counter=MAX_HOLD-1: next edge gnt<=0, state<=IDLE, ptr<=(owner+1) mod NREQ.
REQ-023 Release without beat when req[owner]=0 in BUSY: same updates as REQ-022; no mem_en that cycle.
REQ-024 After release, at least one IDLE cycle precedes the next grant (one-cycle turnaround bubble).
REQ-025 en falling during BUSY SHALL NOT abort the burst; it only blocks the next IDLE arbitration.
REQ-026 Non-owner req/last/addr_in SHALL have no effect while BUSY.
REQ-027 rvalid[i] <= mem_en & gnt[i] each edge; at most one bit set; this tracks the beat even if release happens that edge.
REQ-028 ptr wraps NREQ-1 -> 0; with one requester continuously active it re-wins after each bubble.

Reset
REQ-029 reset_n=0 SHALL immediately force gnt=0, rvalid=0, state=IDLE, ptr=0, counter=0; mem_en=0, mem_addr=0, busy=0.
REQ-030 Reset mid-burst discards the burst; no rvalid for the in-flight beat; first grant after release from reset follows REQ-016 with ptr=0.

Verification
REQ-031 Reset, en=1, req=4'b0001, addr_in[0]=0x100 incrementing, last[0] on 4th beat -> gnt=0001 one cycle after req; mem_addr 0x100..0x103 on 4 consecutive cycles; rvalid[0] 4 cycles delayed by 1; then gnt=0, ptr=1.
REQ-032 req=4'b1111 held, last pulsed on every owner's 2nd beat -> grant order 0,1,2,3,0; one IDLE bubble between each; exactly 2 mem_en per grant.
REQ-033 req[2] held, last never asserted, MAX_HOLD=16 -> exactly 16 beats, forced release, ptr=3, regrant to 2 after one bubble if others idle.
REQ-034 Owner drops req for 1 cycle mid-burst after 3 beats -> release without beat, mem_en=0 that cycle, gnt=0 next edge, no extra rvalid.
REQ-035 en=0 with req=4'b0010 -> no grant; raise en -> gnt=0010 next edge; drop en mid-burst -> burst completes to last.
REQ-036 reset_n pulsed low during beat 2 of a burst -> gnt, rvalid, busy zero immediately; after release req=4'b1000 only -> gnt=1000 one cycle later.
